// File: rtl/sprite_dma_pkg.sv
// Shared constants, encodings and register-index helper for the sprite DMA engine.
package sprite_dma_pkg;

  localparam int unsigned NSPR = 8;
  localparam int unsigned PTRW = 20;

  localparam logic [8:0] SPRPTBASE     = 9'h120;
  localparam logic [8:0] SPRPOSCTLBASE = 9'h140;
  localparam logic [7:0] NOREG         = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } spr_state_t;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_CTLF = 2'd1,
    MODE_DATF = 2'd2
  } line_mode_t;

  // Word-bus register index ([8:1]) of entry n in a register bank with the given byte stride.
  function automatic logic [7:0] reg_idx(input logic [8:0] base, input int unsigned stride,
                                         input int unsigned n);
    return 8'(base[8:1] + 8'(stride * n / 2));
  endfunction

endpackage

// File: rtl/sprite_dma_channel.sv
// One sprite DMA channel: pointer, vertical window, per-line fetch mode and slot match.
module sprite_dma_channel
  import sprite_dma_pkg::*;
#(
  parameter int unsigned IDX      = 0,
  parameter logic [8:0]  SLOTBASE = 9'h02A,
  parameter logic [8:0]  VBSTOP   = 9'd25
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [8:0]      i_hpos,
  input  logic [8:0]      i_vpos,
  input  logic            i_sprdmaen,
  input  logic            i_wr_pth,
  input  logic            i_wr_ptl,
  input  logic            i_wr_pos,
  input  logic            i_wr_ctl,
  input  logic [15:0]     i_data,
  output logic            o_dma_c,
  output logic [7:0]      o_reg_c,
  output logic [PTRW-1:0] o_ptr
);

  localparam logic [8:0] SLOT0  = 9'(SLOTBASE + 9'(8 * IDX));
  localparam logic [8:0] SLOT1  = 9'(SLOT0 + 9'd4);
  localparam logic [7:0] POSREG = reg_idx(SPRPOSCTLBASE, 8, IDX);

  spr_state_t      r_state, w_state_nxt;
  line_mode_t      r_mode, w_mode_nxt;
  logic [PTRW-1:0] r_ptr;
  logic [8:0]      r_vstart, r_vstop;
  logic            w_slot0, w_slot1, w_take;

  assign w_slot0 = (i_hpos == SLOT0);
  assign w_slot1 = (i_hpos == SLOT1);
  assign w_take  = i_sprdmaen && (r_mode != MODE_NONE) && (w_slot0 || w_slot1);
  assign o_dma_c = w_take;
  assign o_ptr   = r_ptr;

  // Destination register: POS/CTL for control fetches, DATA/DATB for data fetches.
  always_comb begin
    o_reg_c = 8'h00;
    if (w_take) begin
      o_reg_c = POSREG + ((r_mode == MODE_DATF) ? 8'd2 : 8'd0) + (w_slot1 ? 8'd1 : 8'd0);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    if (i_hpos == 9'd0) begin
      if (i_vpos == VBSTOP) begin
        w_mode_nxt = MODE_CTLF;
      end else if (r_state == ST_ACTIVE && i_vpos == r_vstop) begin
        w_mode_nxt  = MODE_CTLF;
        w_state_nxt = ST_WAIT;
      end else if (r_state == ST_WAIT && i_vpos == r_vstart && i_vpos == r_vstop) begin
        w_mode_nxt = MODE_CTLF;
      end else if (r_state == ST_WAIT && i_vpos == r_vstart) begin
        w_mode_nxt  = MODE_DATF;
        w_state_nxt = ST_ACTIVE;
      end else if (r_state == ST_ACTIVE) begin
        w_mode_nxt = MODE_DATF;
      end else begin
        w_mode_nxt = MODE_NONE;
      end
    end
    // A CTL write re-arms the sprite even on the line-decision cycle.
    if (i_wr_ctl) begin
      w_state_nxt = ST_WAIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  // Register writes are applied after the increment so CPU-written pointer bits win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_vstart <= '0;
      r_vstop  <= '0;
    end else begin
      if (w_take) begin
        r_ptr <= r_ptr + 20'd1;
      end
      if (i_wr_pth) begin
        r_ptr[19:15] <= i_data[4:0];
      end
      if (i_wr_ptl) begin
        r_ptr[14:0] <= i_data[15:1];
      end
      if (i_wr_pos) begin
        r_vstart[8:1] <= i_data[15:8];
      end
      if (i_wr_ctl) begin
        r_vstop[8:1] <= i_data[15:8];
        r_vstart[0]  <= i_data[2];
        r_vstop[0]   <= i_data[1];
      end
    end
  end

endmodule

// File: rtl/sprite_dma.sv
// Sprite DMA engine top: register decode, eight channels, bus-owner merge.
module sprite_dma
  import sprite_dma_pkg::*;
#(
  parameter logic [8:0] SLOTBASE = 9'h02A,
  parameter logic [8:0] VBSTOP   = 9'd25
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [8:0]      hpos,
  input  logic [8:0]      vpos,
  input  logic            sprdmaen,
  input  logic [7:0]      reg_address_in,
  input  logic [15:0]     data_in,
  output logic            dma,
  output logic [7:0]      reg_address_out,
  output logic [PTRW-1:0] address_out
);

  logic [NSPR-1:0] w_dma;
  logic [NSPR-1:0] w_wr_pth, w_wr_ptl, w_wr_pos, w_wr_ctl;
  logic [7:0]      w_reg [NSPR];
  logic [PTRW-1:0] w_ptr [NSPR];
  logic [7:0]      w_reg_or;

  for (genvar n = 0; n < NSPR; n++) begin : g_spr
    localparam logic [7:0] PTHREG = reg_idx(SPRPTBASE, 4, n);
    localparam logic [7:0] POSREG = reg_idx(SPRPOSCTLBASE, 8, n);

    assign w_wr_pth[n] = (reg_address_in == PTHREG);
    assign w_wr_ptl[n] = (reg_address_in == PTHREG + 8'd1);
    assign w_wr_pos[n] = (reg_address_in == POSREG);
    assign w_wr_ctl[n] = (reg_address_in == POSREG + 8'd1);

    sprite_dma_channel #(
      .IDX      (n),
      .SLOTBASE (SLOTBASE),
      .VBSTOP   (VBSTOP)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .i_hpos     (hpos),
      .i_vpos     (vpos),
      .i_sprdmaen (sprdmaen),
      .i_wr_pth   (w_wr_pth[n]),
      .i_wr_ptl   (w_wr_ptl[n]),
      .i_wr_pos   (w_wr_pos[n]),
      .i_wr_ctl   (w_wr_ctl[n]),
      .i_data     (data_in),
      .o_dma_c    (w_dma[n]),
      .o_reg_c    (w_reg[n]),
      .o_ptr      (w_ptr[n])
    );
  end

  assign dma = |w_dma;

  // Slots never overlap, so at most one channel is selected and an AND-OR merge suffices.
  always_comb begin
    address_out = '0;
    w_reg_or    = '0;
    for (int n = 0; n < NSPR; n++) begin
      if (w_dma[n]) begin
        address_out = address_out | w_ptr[n];
        w_reg_or    = w_reg_or | w_reg[n];
      end
    end
    reg_address_out = dma ? w_reg_or : NOREG;
  end

endmodule
